sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
// - Two-client front end for the single-port SDRAM controller; sits directly upstream of it.
// - Clients: P0 (ROM/loader, ioctl writes) and P1 (core CPU/DMA).
// - Converts level req/ack handshakes into the controller's edge-triggered rd/wr + busy protocol.
// - Holds addr/din/word stable for the whole access and returns read data with a one-cycle ack.
// PARAMETERS
// - AW            25   byte address width; matches the controller addr port
// - RR_EN_PARAM   1    1 = round-robin on contention; 0 = fixed priority, P0 wins
// - REF_INTERVAL  384  idle clocks between forced refresh pulses (SDRAM_ARB_REFRESH_EN only)
// - REF_HOLD      6    clocks after a refresh pulse during which no rd/wr is issued
// PORTS
// - clk        in   1   system clock; same clock as the SDRAM controller
// - reset_n    in   1   asynchronous reset, active low
// - pN_req     in   1   N=0,1; request, held high until pN_ack
// - pN_we      in   1   1 = write, 0 = read; sampled at grant
// - pN_word    in   1   1 = 16-bit access, 0 = byte access (addr[0] selects the byte)
// - pN_addr    in   AW  byte address; sampled at grant
// - pN_din     in   16  write data; sampled at grant
// - pN_dout    out  16  read data; valid from the pN_ack cycle until the next grant to N
// - pN_ack     out  1   one-cycle pulse at completion of N's access
// - sd_addr    out  AW  to controller addr
// - sd_din     out  16  to controller din
// - sd_word    out  1   to controller word
// - sd_rd      out  1   to controller rd; level, rising edge starts a read
// - sd_wr      out  1   to controller wr; level, rising edge starts a write
// - sd_refresh out  1   to controller refresh; one-cycle pulse
// - sd_dout    in   16  from controller dout (byte-swapped for odd byte reads)
// - sd_busy    in   1   from controller busy
// BEHAVIOUR
// - Reset (async, reset_n=0): every output 0; FSM=IDLE; RR pointer favours P0; ref counter 0.
// - FSM states:
//   - IDLE: with >=1 req and hold==0, grant (see arbitration).
//     - Latch we/word/addr/din onto sd_*; record owner; go to ISSUE.
//   - ISSUE: drive sd_rd=~we or sd_wr=we (exactly one high); go to WAIT_BSY.
//   - WAIT_BSY: keep the strobe high until sd_busy=1, then go to WAIT_DONE.
//     - No timeout: the controller defers edges while in init; the held strobe is accepted later.
//   - WAIT_DONE: when sd_busy=0, capture sd_dout into the owner's pN_dout (reads only).
//     - Pulse the owner's pN_ack; drop sd_rd/sd_wr; go to GAP.
//   - GAP: one clock with both strobes low, which guarantees a fresh rising edge; then IDLE.
// - Latency: grant to ack is at least 4 clocks plus the controller busy time (5 clocks nominal).
// - Client rule: pN_req must fall on the cycle after pN_ack.
//   - A req still high in IDLE is treated as a new request.
// - Arbitration: RR_EN_PARAM=1, both req in IDLE -> grant the client not granted last.
//   - RR_EN_PARAM=0 -> P0 always wins. A single requester is granted immediately.
// - sd_addr/sd_din/sd_word stay constant from grant until the next grant.
//   - The controller samples them several clocks after the edge.
// - Requests arriving during an access wait; they are never dropped or merged.
// - The ack goes only to the owner; the other client's pN_dout is untouched.
// - reset_n asserted mid-access: abort immediately, strobes to 0, no ack.
//   - Clients re-request after reset.
// CONFIGURATION
// - `SDRAM_ARB_REFRESH_EN defined:
//   - Refresh counter increments each clock in IDLE with no req; it clears on any grant.
//   - At REF_INTERVAL-1 it emits a one-cycle sd_refresh pulse, clears, and loads hold=REF_HOLD.
//   - Requests seen while hold!=0 wait until hold reaches 0.
//   - sd_refresh never coincides with a strobe edge.
// - Not defined: sd_refresh tied 0, no counter or hold logic; grants are never delayed.
// TESTING
// - P1 read 0x000100, sd_dout=0xBEEF -> one sd_rd edge, sd_addr=0x000100; p1_ack once; p1_dout=0xBEEF.
// - P0 write 0x1234 to 0x0000A0 -> sd_wr edge, sd_din=0x1234 held through busy; p0_ack; sd_rd stays 0.
// - P0 and P1 req on the same cycle, RR_EN_PARAM=1 -> P0 first, then P1 with a GAP between.
//   - Repeat the pair -> P1 first.
// - Hold sd_busy=0 for 50 clocks after ISSUE -> sd_rd stays high, no ack.
//   - Then run a busy pulse -> exactly one ack.
// - Refresh macro on, REF_INTERVAL=16, idle -> sd_refresh pulse every 16 clocks.
//   - A req right after a pulse -> sd_rd rises 6 clocks later.
// - reset_n low during WAIT_DONE -> all outputs 0 immediately, no ack; the next req completes normally.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: two client request ports plus the SDRAM controller side bus.
interface sdram_arbiter_if #(parameter int AW = 25);
  logic [1:0]          req, we, word, ack;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][15:0]    din, dout;
  logic [AW-1:0]       sd_addr;
  logic [15:0]         sd_din, sd_dout;
  logic                sd_word, sd_rd, sd_wr, sd_refresh, sd_busy;
  modport slave (input req, we, word, addr, din, sd_dout, sd_busy,
                 output ack, dout, sd_addr, sd_din, sd_word, sd_rd, sd_wr, sd_refresh);
  modport master (output req, we, word, addr, din, sd_dout, sd_busy,
                  input ack, dout, sd_addr, sd_din, sd_word, sd_rd, sd_wr, sd_refresh);
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-client req/ack front end for the single-port SDRAM controller.
// Define SDRAM_ARB_REFRESH_EN to add the idle refresh counter and post-refresh hold.
module sdram_arbiter #(
  parameter int AW = 25,
  parameter int RR_EN_PARAM = 1
`ifdef SDRAM_ARB_REFRESH_EN
  , parameter int REF_INTERVAL = 384,
  parameter int REF_HOLD = 6
`endif
) (
  input logic clk,
  input logic reset_n,
  sdram_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BSY, WAIT_DONE, GAP} state_t;
  state_t state, state_nx;
  logic owner, we_q, rr, pick, grant, done, strobe, hold_ok;
  logic [AW-1:0] g_addr;
  // rr names the client that wins the next contention; it only moves on contention
  assign pick = (&bus.req) ? ((RR_EN_PARAM != 0) && rr) : bus.req[1];
  assign grant = (state == IDLE) && (|bus.req) && hold_ok;
  assign done = (state == WAIT_DONE) && !bus.sd_busy;
  assign strobe = state inside {ISSUE, WAIT_BSY, WAIT_DONE};
  assign bus.sd_rd = strobe && !we_q;
  assign bus.sd_wr = strobe && we_q;
  assign g_addr = bus.addr[pick];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = grant ? ISSUE : IDLE;
      ISSUE:     state_nx = WAIT_BSY;
      WAIT_BSY:  state_nx = bus.sd_busy ? WAIT_DONE : WAIT_BSY;
      WAIT_DONE: state_nx = bus.sd_busy ? WAIT_DONE : GAP;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= 1'b0;
      we_q <= 1'b0;
      rr <= 1'b0;
      bus.sd_addr <= '0;
      bus.sd_din <= '0;
      bus.sd_word <= 1'b0;
      bus.ack <= '0;
      bus.dout <= '0;
    end else begin
      state <= state_nx;
      bus.ack <= {2{done}} & {owner, ~owner};
      if (grant) begin
        owner <= pick;
        we_q <= bus.we[pick];
        bus.sd_addr <= g_addr;
        bus.sd_din <= bus.din[pick];
        bus.sd_word <= bus.word[pick];
        if (&bus.req) rr <= ~pick;
      end
      if (done && !we_q) bus.dout[owner] <= bus.sd_dout;
    end
  end
`ifdef SDRAM_ARB_REFRESH_EN
  localparam int CW = $clog2(REF_INTERVAL);
  localparam int HW = $clog2(REF_HOLD + 1);
  logic [CW-1:0] ref_cnt;
  logic [HW-1:0] hold;
  logic ref_idle, ref_fire;
  assign ref_idle = (state == IDLE) && !(|bus.req);
  assign ref_fire = ref_idle && (ref_cnt == CW'(REF_INTERVAL - 1));
  assign hold_ok = (hold == '0);
  // the pulse is only ever raised from an idle cycle, and hold blocks the following grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt <= '0;
      hold <= '0;
      bus.sd_refresh <= 1'b0;
    end else begin
      bus.sd_refresh <= ref_fire;
      hold <= ref_fire ? HW'(REF_HOLD) : hold - HW'(hold != '0);
      ref_cnt <= (grant || ref_fire) ? '0 : ref_idle ? ref_cnt + 1'b1 : ref_cnt;
    end
  end
`else
  assign hold_ok = 1'b1;
  assign bus.sd_refresh = 1'b0;
`endif
endmodule
